// File: rtl/jk_ctrl_pkg.sv
// Shared types, mode encodings and Gray-code helpers for the JK counter controller.
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10,
    StDone = 2'b11
  } state_e;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;
  localparam logic [1:0] MODE_RING = 2'b11;

  localparam int unsigned MaxWidth = 16;

  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] g);
    logic [MaxWidth-1:0] b;
    b[MaxWidth-1] = g[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Maps (current, planned next, enable) to minimal JK excitation; don't-cares resolve to 0.
module jk_excite
  import jk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_cur,
  input  logic [WIDTH-1:0] i_nxt,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_j,
  output logic [WIDTH-1:0] o_k
);

  always_comb begin
    o_j = '0;
    o_k = '0;
    if (i_en) begin
      o_j = ~i_cur & i_nxt;
      o_k = i_cur & ~i_nxt;
    end
  end

endmodule

// File: rtl/jk_counter_ctrl.sv
// Mode-programmable counter built from a JK flip-flop bank with start/stop/done handshake.
module jk_counter_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] term,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_q,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done
);

  state_e r_state, w_state_d;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_term;
  logic             w_latch;
  logic             w_en;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_count;

  logic [MaxWidth-1:0] w_bin16;
  logic [MaxWidth-1:0] w_gray16;
  logic [WIDTH-1:0]    w_bin_inc;
  logic                w_unused;

  assign w_bin16   = gray2bin(MaxWidth'(w_count));
  assign w_bin_inc = w_bin16[WIDTH-1:0] + WIDTH'(1);
  assign w_gray16  = bin2gray(MaxWidth'(w_bin_inc));
  assign w_unused  = ^{w_bin16, w_gray16};

  always_comb begin
    w_next = w_count + WIDTH'(1);
    case (r_mode)
      MODE_DOWN: w_next = w_count - WIDTH'(1);
      MODE_GRAY: w_next = w_gray16[WIDTH-1:0];
      MODE_RING: w_next = (w_count == '0) ? WIDTH'(1) : {w_count[WIDTH-2:0], w_count[WIDTH-1]};
      default:   w_next = w_count + WIDTH'(1);
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_latch   = 1'b0;
    w_en      = 1'b0;
    w_target  = w_count;
    case (r_state)
      StIdle: begin
        if (load) begin
          w_en     = 1'b1;
          w_target = load_val;
        end else if (start) begin
          w_latch   = 1'b1;
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          w_state_d = StHold;
        end else if (w_count == r_term) begin
          w_state_d = StDone;
        end else begin
          w_en     = 1'b1;
          w_target = w_next;
        end
      end
      StHold: begin
        if (stop) begin
          w_state_d = StIdle;
        end else if (start) begin
          w_state_d = StRun;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Excitation is suppressed while reset holds the bank clear.
    if (reset) begin
      w_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_mode  <= 2'b00;
      r_term  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_latch) begin
        r_mode <= mode;
        r_term <= term;
      end
    end
  end

  jk_excite #(
    .WIDTH(WIDTH)
  ) u_excite (
    .i_cur(w_count),
    .i_nxt(w_target),
    .i_en (w_en),
    .o_j  (j_out),
    .o_k  (k_out)
  );

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    logic r_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_q <= 1'b0;
      end else begin
        case ({j_out[g], k_out[g]})
          2'b10:   r_q <= 1'b1;
          2'b01:   r_q <= 1'b0;
          2'b11:   r_q <= ~r_q;
          default: r_q <= r_q;
        endcase
      end
    end
    assign w_count[g] = r_q;
  end

  assign count_q = w_count;
  assign busy    = (r_state == StRun) || (r_state == StHold);
  assign done    = (r_state == StDone);

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Directed-vector bench for jk_counter_ctrl with WIDTH = 4.
module tb_jk_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop, load;
  logic [1:0] mode;
  logic [3:0] term, load_val;
  logic [3:0] count_q, j_out, k_out;
  logic       busy, done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jk_counter_ctrl #(
    .WIDTH(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .term    (term),
    .load    (load),
    .load_val(load_val),
    .count_q (count_q),
    .j_out   (j_out),
    .k_out   (k_out),
    .busy    (busy),
    .done    (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
    n_vec++;
    if (count_q !== v) begin n_err++; $display("FAIL load got %0d want %0d", count_q, v); end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [3:0] t);
    mode = m; term = t; start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy got %b want 1", busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; stop = 0; load = 0; mode = 0; term = 0; load_val = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if ({count_q, busy, done, j_out, k_out} !== 14'd0) begin
      n_err++;
      $display("FAIL reset got cnt=%0d busy=%b done=%b j=%b k=%b want all 0",
               count_q, busy, done, j_out, k_out);
    end
  endtask

  task automatic test_up();
    logic [3:0] prev;
    do_load(4'd0);
    do_start(2'b00, 4'd9);
    for (int i = 1; i <= 9; i++) begin
      prev = 4'(i - 1);
      n_vec++;
      if (j_out !== (~prev & 4'(i)) || k_out !== (prev & ~4'(i))) begin
        n_err++; $display("FAIL up_exc step %0d got j=%b k=%b", i, j_out, k_out);
      end
      tick();
      n_vec++;
      if (count_q !== 4'(i)) begin n_err++; $display("FAIL up_cnt got %0d want %0d", count_q, i); end
    end
    n_vec++;
    if (j_out !== 4'd0 || k_out !== 4'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL up_at_term got j=%b k=%b done=%b want 0 0 0", j_out, k_out, done);
    end
    tick();
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || count_q !== 4'd9) begin
      n_err++; $display("FAIL up_done got done=%b busy=%b cnt=%0d want 1 0 9", done, busy, count_q);
    end
    tick();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || count_q !== 4'd9) begin
      n_err++; $display("FAIL up_idle got done=%b busy=%b cnt=%0d want 0 0 9", done, busy, count_q);
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] seq [4] = '{4'd1, 4'd0, 4'd15, 4'd14};
    // From 9 (1001) loading 1 (0001) only clears bit 3.
    load = 1'b1; load_val = 4'd1;
    #1;
    n_vec++;
    if (j_out !== 4'b0000 || k_out !== 4'b1000) begin
      n_err++; $display("FAIL load_exc got j=%b k=%b want 0000 1000", j_out, k_out);
    end
    do_load(4'd1);
    do_start(2'b01, 4'd14);
    for (int i = 1; i < 4; i++) begin
      tick();
      n_vec++;
      if (count_q !== seq[i]) begin n_err++; $display("FAIL down_cnt got %0d want %0d", count_q, seq[i]); end
    end
    n_vec++;
    if (j_out !== 4'd0 || k_out !== 4'd0) begin
      n_err++; $display("FAIL down_hold_exc got j=%b k=%b want 0 0", j_out, k_out);
    end
    tick();
    n_vec++;
    if (done !== 1'b1 || count_q !== 4'd14) begin
      n_err++; $display("FAIL down_done got done=%b cnt=%0d want 1 14", done, count_q);
    end
    tick();
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL down_done_once got done=%b want 0", done); end
  endtask

  task automatic test_gray();
    logic [3:0] seq [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                             4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    do_load(4'd0);
    do_start(2'b10, 4'b1000);
    for (int i = 1; i < 16; i++) begin
      n_vec++;
      if (j_out !== (~seq[i-1] & seq[i]) || k_out !== (seq[i-1] & ~seq[i]) ||
          $countones(j_out | k_out) != 1) begin
        n_err++; $display("FAIL gray_exc step %0d got j=%b k=%b", i, j_out, k_out);
      end
      tick();
      n_vec++;
      if (count_q !== seq[i]) begin n_err++; $display("FAIL gray_cnt got %b want %b", count_q, seq[i]); end
    end
    tick();
    n_vec++;
    if (done !== 1'b1) begin n_err++; $display("FAIL gray_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_ring();
    logic [3:0] seq [6] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2};
    do_load(4'd0);
    do_start(2'b11, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (count_q !== seq[i]) begin n_err++; $display("FAIL ring_cnt got %0d want %0d", count_q, seq[i]); end
    end
    tick();
    n_vec++;
    if (done !== 1'b1) begin n_err++; $display("FAIL ring_done got %b want 1", done); end
    tick();
    do_load(4'd0);
    do_start(2'b11, 4'b0101);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (count_q !== seq[i] || done !== 1'b0) begin
        n_err++; $display("FAIL ring_cycle got cnt=%0d done=%b want %0d 0", count_q, done, seq[i]);
      end
    end
    stop = 1'b1;
    tick();
    n_vec++;
    if (busy !== 1'b1 || count_q !== 4'd2) begin
      n_err++; $display("FAIL ring_hold got busy=%b cnt=%0d want 1 2", busy, count_q);
    end
    tick();
    stop = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || count_q !== 4'd2) begin
      n_err++; $display("FAIL ring_abort got busy=%b done=%b cnt=%0d want 0 0 2", busy, done, count_q);
    end
  endtask

  task automatic test_handshake();
    do_load(4'd0);
    do_start(2'b00, 4'd15);
    tick(); tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (count_q !== 4'd3 || busy !== 1'b1 || j_out !== 4'd0 || k_out !== 4'd0) begin
        n_err++; $display("FAIL hold got cnt=%0d busy=%b j=%b k=%b want 3 1 0 0",
                          count_q, busy, j_out, k_out);
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    load = 1'b1; load_val = 4'd12;
    tick();
    load = 1'b0;
    n_vec++;
    if (count_q !== 4'd4) begin n_err++; $display("FAIL resume_noload got %0d want 4", count_q); end
    stop = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || count_q !== 4'd4) begin
      n_err++; $display("FAIL startstop got busy=%b done=%b cnt=%0d want 0 0 4", busy, done, count_q);
    end
  endtask

  task automatic test_reset_mid_run();
    do_load(4'd0);
    do_start(2'b00, 4'd15);
    for (int i = 0; i < 6; i++) tick();
    n_vec++;
    if (count_q !== 4'd6) begin n_err++; $display("FAIL pre_reset got %0d want 6", count_q); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if ({count_q, busy, done, j_out, k_out} !== 14'd0) begin
      n_err++;
      $display("FAIL mid_reset got cnt=%0d busy=%b done=%b j=%b k=%b want all 0",
               count_q, busy, done, j_out, k_out);
    end
    tick();
    n_vec++;
    if (count_q !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL post_reset got cnt=%0d busy=%b done=%b", count_q, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down_wrap();
    test_gray();
    test_ring();
    test_handshake();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
